// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - digit constants and wrap/saturation helpers for bcd_tick_counter
package counter_pkg;

  localparam int         DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam int         MAX_W   = 64;

  function automatic logic [DIGIT_W-1:0] sat_digit(input logic [DIGIT_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

  function automatic logic [MAX_W-1:0] all_nines(input int ndig);
    logic [MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_W / DIGIT_W; i++) begin
      if (i < ndig) v[i*DIGIT_W +: DIGIT_W] = BCD_MAX;
    end
    return v;
  endfunction

  function automatic logic [MAX_W-1:0] all_ones(input int w);
    logic [MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - next-value logic for one counter digit (BCD 0-9 or hex nibble)
module bcd_digit
  import counter_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_digit,
  input  logic               i_inc,
  input  logic               i_dec,
  input  logic               i_carry_in,
  input  logic               i_bcd,
  output logic [DIGIT_W-1:0] o_digit,
  output logic               o_carry_out
);

  logic [DIGIT_W-1:0] w_max;

  assign w_max = i_bcd ? BCD_MAX : DIGIT_W'(all_ones(DIGIT_W));

  // i_carry_in is the ripple enable: a digit only moves when every lower digit wrapped
  always_comb begin
    o_digit     = i_digit;
    o_carry_out = 1'b0;
    if (i_carry_in && i_inc) begin
      if (i_digit >= w_max) begin
        o_digit     = '0;
        o_carry_out = 1'b1;
      end else begin
        o_digit = i_digit + 4'd1;
      end
    end else if (i_carry_in && i_dec) begin
      if (i_digit == '0) begin
        o_digit     = w_max;
        o_carry_out = 1'b1;
      end else begin
        o_digit = i_digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_tick_counter.sv
// rtl/bcd_tick_counter.sv - prescaled BCD/binary up/down counter with load, clear and wrap pulse
module bcd_tick_counter
  import counter_pkg::*;
#(
  parameter int DIV  = 500,
  parameter int NDIG = 4,
  parameter int BCD  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    up,
  input  logic                    clr,
  input  logic                    load,
  input  logic [DIGIT_W*NDIG-1:0] load_val,
  output logic [DIGIT_W*NDIG-1:0] count,
  output logic                    tick,
  output logic                    tc
);

  localparam int W  = DIGIT_W * NDIG;
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  logic [PW-1:0] r_pre;
  logic [W-1:0]  r_count;
  logic          r_tick;
  logic          r_tc;
  logic [W-1:0]  w_next;
  logic [W-1:0]  w_load_sat;
  logic [NDIG:0] w_carry;
  logic          w_step;

  assign w_step     = en && (r_pre == PRE_LAST);
  assign w_carry[0] = 1'b1;

  for (genvar g = 0; g < NDIG; g++) begin : g_digit
    bcd_digit u_digit (
      .i_digit     (r_count[g*DIGIT_W +: DIGIT_W]),
      .i_inc       (up),
      .i_dec       (!up),
      .i_carry_in  (w_carry[g]),
      .i_bcd       (BCD != 0),
      .o_digit     (w_next[g*DIGIT_W +: DIGIT_W]),
      .o_carry_out (w_carry[g+1])
    );
  end

  always_comb begin
    w_load_sat = load_val;
    if (BCD != 0) begin
      for (int i = 0; i < NDIG; i++) begin
        w_load_sat[i*DIGIT_W +: DIGIT_W] = sat_digit(load_val[i*DIGIT_W +: DIGIT_W]);
      end
    end
  end

  // carry out of the top digit is exactly the whole-count wrap in either direction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_pre   <= '0;
      r_tick  <= 1'b0;
      r_tc    <= 1'b0;
    end else if (clr) begin
      r_count <= '0;
      r_pre   <= '0;
      r_tick  <= 1'b0;
      r_tc    <= 1'b0;
    end else if (load) begin
      r_count <= w_load_sat;
      r_pre   <= '0;
      r_tick  <= 1'b0;
      r_tc    <= 1'b0;
    end else if (w_step) begin
      r_count <= w_next;
      r_pre   <= '0;
      r_tick  <= 1'b1;
      r_tc    <= w_carry[NDIG];
    end else begin
      if (en) r_pre <= r_pre + PW'(1);
      r_tick <= 1'b0;
      r_tc   <= 1'b0;
    end
  end

  assign count = r_count;
  assign tick  = r_tick;
  assign tc    = r_tc;

endmodule

// File: tb/tb_bcd_tick_counter.sv
// tb/tb_bcd_tick_counter.sv - randomized bench for bcd_tick_counter, BCD and binary instances
module tb_bcd_tick_counter;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n, en, up, clr, load;
  logic [7:0] load_val;
  logic [7:0] count_bcd, count_bin;
  logic       tick_bcd, tick_bin, tc_bcd, tc_bin;

  int n_checks = 0;
  int n_err    = 0;

  // model state: plain integer values, shared prescaler phase
  int m_pre;
  int m_val  [2];
  bit m_tick [2];
  bit m_tc   [2];

  always #5 clk = ~clk;

  bcd_tick_counter #(.DIV(DIV), .NDIG(2), .BCD(1)) u_dut_bcd (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .count(count_bcd), .tick(tick_bcd), .tc(tc_bcd)
  );

  bcd_tick_counter #(.DIV(DIV), .NDIG(2), .BCD(0)) u_dut_bin (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .count(count_bin), .tick(tick_bin), .tc(tc_bin)
  );

  function automatic int decode(input logic [7:0] lv, input bit bcd);
    int lo, hi;
    if (!bcd) return int'(lv);
    lo = (lv[3:0] > 4'd9) ? 9 : int'(lv[3:0]);
    hi = (lv[7:4] > 4'd9) ? 9 : int'(lv[7:4]);
    return hi * 10 + lo;
  endfunction

  function automatic logic [7:0] encode(input int v, input bit bcd);
    if (!bcd) return 8'(v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pre <= 0;
      for (int k = 0; k < 2; k++) begin
        m_val[k] <= 0; m_tick[k] <= 1'b0; m_tc[k] <= 1'b0;
      end
    end else if (clr || load) begin
      m_pre <= 0;
      for (int k = 0; k < 2; k++) begin
        m_val[k]  <= clr ? 0 : decode(load_val, k == 0);
        m_tick[k] <= 1'b0; m_tc[k] <= 1'b0;
      end
    end else if (en && m_pre == DIV - 1) begin
      m_pre <= 0;
      for (int k = 0; k < 2; k++) begin
        if (up) begin
          m_tc[k]  <= (m_val[k] == ((k == 0) ? 99 : 255));
          m_val[k] <= (m_val[k] + 1) % ((k == 0) ? 100 : 256);
        end else begin
          m_tc[k]  <= (m_val[k] == 0);
          m_val[k] <= (m_val[k] + ((k == 0) ? 99 : 255)) % ((k == 0) ? 100 : 256);
        end
        m_tick[k] <= 1'b1;
      end
    end else begin
      if (en) m_pre <= m_pre + 1;
      for (int k = 0; k < 2; k++) begin
        m_tick[k] <= 1'b0; m_tc[k] <= 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    check("model count_bcd", count_bcd, encode(m_val[0], 1'b1));
    check("model tick_bcd",  {7'd0, tick_bcd}, {7'd0, m_tick[0]});
    check("model tc_bcd",    {7'd0, tc_bcd},   {7'd0, m_tc[0]});
    check("model count_bin", count_bin, encode(m_val[1], 1'b0));
    check("model tick_bin",  {7'd0, tick_bin}, {7'd0, m_tick[1]});
    check("model tc_bin",    {7'd0, tc_bin},   {7'd0, m_tc[1]});
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      cmp_model();
    end
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1; load_val = v;
    cyc(1);
    load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; load_val = 8'h00;
    cyc(2);
    check("reset count", count_bcd, 8'h00);
    check("reset tick",  {7'd0, tick_bcd}, 8'h00);

    // cadence after release
    rst_n = 1'b1; en = 1'b1; up = 1'b1;
    cyc(3);
    check("pre-step tick", {7'd0, tick_bcd}, 8'h00);
    cyc(1);
    check("step1 count", count_bcd, 8'h01);
    check("step1 tick",  {7'd0, tick_bcd}, 8'h01);
    cyc(4);
    check("step2 count", count_bcd, 8'h02);

    // decimal wrap up
    do_load(8'h99);
    check("load 99", count_bcd, 8'h99);
    cyc(4);
    check("wrap99 count", count_bcd, 8'h00);
    check("wrap99 tc",    {7'd0, tc_bcd}, 8'h01);
    check("bin 99 up",    count_bin, 8'h9A);
    do_load(8'h09);
    cyc(4);
    check("carry 09", count_bcd, 8'h10);
    check("carry 09 tc", {7'd0, tc_bcd}, 8'h00);

    // wrap down and binary
    up = 1'b0;
    do_load(8'h00);
    cyc(4);
    check("down wrap bcd", count_bcd, 8'h99);
    check("down wrap bin", count_bin, 8'hFF);
    check("down tc bin",   {7'd0, tc_bin}, 8'h01);
    up = 1'b1;
    do_load(8'h0F);
    cyc(4);
    check("bin 0F up", count_bin, 8'h10);
    check("bin 0F tc", {7'd0, tc_bin}, 8'h00);

    // saturation and priority
    do_load(8'h3C);
    check("sat 3C", count_bcd, 8'h39);
    check("nosat bin 3C", count_bin, 8'h3C);
    clr = 1'b1; load = 1'b1; load_val = 8'h42;
    cyc(1);
    clr = 1'b0; load = 1'b0;
    check("clr over load", count_bcd, 8'h00);
    cyc(3);
    do_load(8'h25);
    check("load on step tick", {7'd0, tick_bcd}, 8'h00);
    cyc(3);
    check("post load no tick", {7'd0, tick_bcd}, 8'h00);
    cyc(1);
    check("post load step", count_bcd, 8'h26);

    // enable gating at the last prescaler phase
    cyc(3);
    en = 1'b0;
    cyc(3);
    check("gated count", count_bcd, 8'h26);
    check("gated tick",  {7'd0, tick_bcd}, 8'h00);
    en = 1'b1;
    cyc(1);
    check("resume step", count_bcd, 8'h27);

    // async reset between edges
    do_load(8'h56);
    cyc(4);
    check("before reset", count_bcd, 8'h57);
    #2 rst_n = 1'b0;
    #1;
    check("async count", count_bcd, 8'h00);
    check("async tick",  {7'd0, tick_bcd}, 8'h00);
    check("async tc",    {7'd0, tc_bcd}, 8'h00);
    cyc(1);
    rst_n = 1'b1;
    cyc(3);
    check("after reset hold", count_bcd, 8'h00);
    cyc(1);
    check("after reset step", count_bcd, 8'h01);

    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      en       = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) up = ~up;
      clr      = ($urandom_range(0, 99) == 0);
      load     = ($urandom_range(0, 59) == 0);
      load_val = 8'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      cyc(1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
